// File: rtl/gate_stim_checker_pkg.sv
// ---------------------------------------------------------------------------
// gate_stim_checker_pkg
//   Shared definitions for the gate stage stimulus/checker:
//     - state_e   : FSM state encoding (IDLE, DRIVE, SAMPLE, DONE)
//     - VEC_LAST  : index of the final vector in the table
//     - vec_ab()  : 4-entry {a,b} vector table (Gray order, one bit per step)
//     - hold_eff(): legalised hold time (0 behaves as 1)
// ---------------------------------------------------------------------------
package gate_stim_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRIVE  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [1:0] VEC_FIRST = 2'd0;
    localparam logic [1:0] VEC_LAST  = 2'd3;

    // Vector table as {a,b}: 00, 01, 11, 10.
    function automatic logic [1:0] vec_ab(input logic [1:0] idx);
        logic [1:0] ab;
        case (idx)
            2'd0:    ab = 2'b00;
            2'd1:    ab = 2'b01;
            2'd2:    ab = 2'b11;
            default: ab = 2'b10;
        endcase
        return ab;
    endfunction

    function automatic int unsigned hold_eff(input int unsigned hold);
        return (hold == 0) ? 1 : hold;
    endfunction

endpackage

// File: rtl/gate_stim_checker_hold_counter.sv
// ---------------------------------------------------------------------------
// hold_counter
//   Loadable down-counter used to time how long each vector is held.
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset (count -> 0)
//     load_i     load load_val_i (has priority over en_i)
//     load_val_i value to load
//     en_i       decrement by one
//     count_o    current count
//     zero_o     count_o == 0
// ---------------------------------------------------------------------------
module hold_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic         zero_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (en_i) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/gate_stim_checker.sv
// ---------------------------------------------------------------------------
// gate_stim_checker
//   Self-running stimulus sequencer and response checker for a combinational
//   NAND_2 / NOT_1 gate stage. Walks {a,b} through 00,01,11,10, holds each
//   vector HOLD_CYC cycles, samples the gate outputs for one cycle and counts
//   vectors with any mismatch against the ideal truth table.
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     start      run request, honoured only in IDLE
//     a_out      registered drive to gate input A (also drives NOT_1)
//     b_out      registered drive to gate input B
//     y_nand_in  NAND_2 output under test
//     y_not_in   NOT_1 output under test
//     busy       first DRIVE cycle through last SAMPLE cycle
//     done       one-cycle pulse on run completion
//     pass       last completed run had no mismatches; cleared on start
//     err_cnt    vectors with any mismatch (0..4)
//     vec_idx    index of the vector currently driven
// ---------------------------------------------------------------------------
module gate_stim_checker
    import gate_stim_checker_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 4,
    parameter int unsigned HOLD_W   = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_nand_in,
    input  logic       y_not_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_cnt,
    output logic [1:0] vec_idx
);

    localparam int unsigned       HOLD_EFF  = hold_eff(HOLD_CYC);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_EFF - 1);

    state_e      state_q;
    logic        a_q;
    logic        b_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [2:0]  err_q;
    logic [1:0]  vec_q;

    logic              cnt_load;
    logic              cnt_en;
    logic              cnt_zero;
    logic [HOLD_W-1:0] hold_cnt;
    logic [1:0]        vec_nxt;
    logic [1:0]        ab_nxt;
    logic              mismatch;
    logic [2:0]        err_inc;

    // Counter loads on run start and on every SAMPLE->DRIVE step, so DRIVE
    // lasts exactly HOLD_EFF cycles (load value HOLD_EFF-1 counted down to 0).
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        if ((state_q == ST_IDLE) && start) begin
            cnt_load = 1'b1;
        end
        if ((state_q == ST_SAMPLE) && (vec_q != VEC_LAST)) begin
            cnt_load = 1'b1;
        end
        if ((state_q == ST_DRIVE) && (hold_cnt != '0)) begin
            cnt_en = 1'b1;
        end
    end

    hold_counter #(
        .W (HOLD_W)
    ) u_hold_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (HOLD_LOAD),
        .en_i       (cnt_en),
        .count_o    (hold_cnt),
        .zero_o     (cnt_zero)
    );

    // Gate outputs are combinational from a_q/b_q in this clock domain,
    // so they are compared directly without synchronisation.
    always_comb begin
        vec_nxt  = vec_q + 2'd1;
        ab_nxt   = vec_ab(vec_nxt);
        mismatch = (y_nand_in != ~(a_q & b_q)) || (y_not_in != ~a_q);
        err_inc  = err_q + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= '0;
            vec_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q      <= ST_DRIVE;
                        vec_q        <= VEC_FIRST;
                        {a_q, b_q}   <= vec_ab(VEC_FIRST);
                        err_q        <= '0;
                        pass_q       <= 1'b0;
                        busy_q       <= 1'b1;
                    end
                end

                ST_DRIVE: begin
                    if (cnt_zero) begin
                        state_q <= ST_SAMPLE;
                    end
                end

                ST_SAMPLE: begin
                    if (mismatch) begin
                        err_q <= err_inc;
                    end
                    if (vec_q == VEC_LAST) begin
                        // Outputs of the DONE cycle are registered here so
                        // that done/pass/busy are valid throughout DONE.
                        state_q    <= ST_DONE;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        pass_q     <= (err_q == '0) && !mismatch;
                        {a_q, b_q} <= 2'b00;
                        vec_q      <= VEC_FIRST;
                    end else begin
                        state_q    <= ST_DRIVE;
                        vec_q      <= vec_nxt;
                        {a_q, b_q} <= ab_nxt;
                    end
                end

                ST_DONE: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign a_out   = a_q;
    assign b_out   = b_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign pass    = pass_q;
    assign err_cnt = err_q;
    assign vec_idx = vec_q;

endmodule

// File: tb/tb_gate_stim_checker.sv
module tb_gate_stim_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start_v [3];
    int         mode_v  [3];
    logic       a_v     [3];
    logic       b_v     [3];
    logic       yn_v    [3];
    logic       yt_v    [3];
    logic       busy_v  [3];
    logic       done_v  [3];
    logic       pass_v  [3];
    logic [2:0] err_v   [3];
    logic [1:0] vec_v   [3];

    int checks = 0;
    int errors = 0;

    logic [1:0] vec_tab [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    // Fault models: 0 ideal, 1 NAND stuck-1, 2 NAND stuck-0,
    // 3 NOT non-inverting, 4 both outputs wrong on {a,b}=01 only.
    function automatic logic [1:0] gate_model(input int mode, input logic a, input logic b);
        logic n;
        logic t;
        n = ~(a & b);
        t = ~a;
        case (mode)
            1: n = 1'b1;
            2: n = 1'b0;
            3: t = a;
            4: if (!a && b) begin n = a & b; t = a; end
            default: ;
        endcase
        return {n, t};
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_gate
        assign {yn_v[g], yt_v[g]} = gate_model(mode_v[g], a_v[g], b_v[g]);
    end

    gate_stim_checker #(.HOLD_CYC(4), .HOLD_W(8)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a_out(a_v[0]), .b_out(b_v[0]),
        .y_nand_in(yn_v[0]), .y_not_in(yt_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .pass(pass_v[0]), .err_cnt(err_v[0]), .vec_idx(vec_v[0]));

    gate_stim_checker #(.HOLD_CYC(1), .HOLD_W(8)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a_out(a_v[1]), .b_out(b_v[1]),
        .y_nand_in(yn_v[1]), .y_not_in(yt_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .pass(pass_v[1]), .err_cnt(err_v[1]), .vec_idx(vec_v[1]));

    gate_stim_checker #(.HOLD_CYC(0), .HOLD_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a_out(a_v[2]), .b_out(b_v[2]),
        .y_nand_in(yn_v[2]), .y_not_in(yt_v[2]), .busy(busy_v[2]), .done(done_v[2]),
        .pass(pass_v[2]), .err_cnt(err_v[2]), .vec_idx(vec_v[2]));

    // {a, b, vec_idx, busy, done, err_cnt, pass}
    function automatic logic [9:0] obs(input int i);
        return {a_v[i], b_v[i], vec_v[i], busy_v[i], done_v[i], err_v[i], pass_v[i]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_v[i] = 1'b0;
            mode_v[i]  = 0;
        end
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (obs(i) !== 10'b0) begin
                errors++;
                $display("FAIL reset inst=%0d got=%b exp=%b", i, obs(i), 10'b0);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Full run on one instance: the expected per-cycle outputs are queued as
    // the run is launched, then popped and compared every cycle.
    task automatic run_seq(input int inst, input int hold, input int mode,
                           input int exp_err, input bit extra_starts);
        logic [9:0] sb[$];
        logic [9:0] expv;
        logic [9:0] got;
        logic [1:0] ab;
        logic [1:0] gm;
        int he;
        int err_run;
        int cyc;
        he      = (hold == 0) ? 1 : hold;
        err_run = 0;
        mode_v[inst] = mode;
        @(negedge clk);
        start_v[inst] = 1'b1;
        for (int v = 0; v < 4; v++) begin
            ab = vec_tab[v];
            for (int c = 0; c <= he; c++)
                sb.push_back({ab, 2'(v), 1'b1, 1'b0, 3'(err_run), 1'b0});
            gm = gate_model(mode, ab[1], ab[0]);
            if (gm[1] !== ~(ab[1] & ab[0]) || gm[0] !== ~ab[1]) err_run++;
        end
        sb.push_back({2'b00, 2'b00, 1'b0, 1'b1, 3'(err_run), (err_run == 0)});
        sb.push_back({2'b00, 2'b00, 1'b0, 1'b0, 3'(err_run), (err_run == 0)});
        @(negedge clk);
        start_v[inst] = 1'b0;
        cyc = 0;
        while (sb.size() > 0) begin
            expv = sb.pop_front();
            got  = obs(inst);
            checks++;
            if (got !== expv) begin
                errors++;
                $display("FAIL seq inst=%0d mode=%0d cyc=%0d got=%b exp=%b", inst, mode, cyc, got, expv);
            end
            start_v[inst] = extra_starts && (cyc == 2 || sb.size() == 1);
            @(negedge clk);
            cyc++;
        end
        start_v[inst] = 1'b0;
        checks++;
        if (err_v[inst] !== 3'(exp_err) || pass_v[inst] !== (exp_err == 0)) begin
            errors++;
            $display("FAIL result inst=%0d mode=%0d got err=%0d pass=%b exp err=%0d pass=%b",
                     inst, mode, err_v[inst], pass_v[inst], exp_err, (exp_err == 0));
        end
    endtask

    task automatic test_ideal();
        run_seq(0, 4, 0, 0, 1'b0);
    endtask

    task automatic test_faults();
        run_seq(0, 4, 1, 1, 1'b0);
        run_seq(0, 4, 2, 3, 1'b0);
        run_seq(0, 4, 3, 4, 1'b0);
        run_seq(0, 4, 4, 1, 1'b0);
    endtask

    task automatic test_reset_midrun();
        int n;
        bit bad;
        mode_v[0] = 0;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        n = 0;
        while (vec_v[0] !== 2'd2 && n < 60) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 60) begin
            errors++;
            $display("FAIL reach_vec2 got=%0d exp=%0d", vec_v[0], 2);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (obs(0) !== 10'b0) begin
            errors++;
            $display("FAIL async_reset got=%b exp=%b", obs(0), 10'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (done_v[0] !== 1'b0 || busy_v[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL no_done_after_abort got=1 exp=0");
        end
        run_seq(0, 4, 0, 0, 1'b0);
    endtask

    task automatic test_short_hold();
        run_seq(1, 1, 0, 0, 1'b1);
        run_seq(2, 0, 0, 0, 1'b1);
        run_seq(1, 1, 2, 3, 1'b0);
        run_seq(2, 0, 2, 3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_faults();
        test_reset_midrun();
        test_short_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
